lif_scheduler: RTL and testbench
================================

Name: lif_scheduler

Overview:
Time-multiplexes one LIF neuron update datapath across NUM_NEURONS neurons, each held in an internal membrane-state register file.
- On each timestep request it fetches one input current per neuron over a valid/ready stream, in neuron-index order.
- It updates that neuron's membrane state and emits one spike record per neuron over a second valid/ready stream.
- Sits between the chip-level input pins/host and the spike output logic; replaces per-neuron LIF instances when more than one neuron is needed.

Parameters:
NUM_NEURONS, 4, neurons served per timestep; power of two, ≥2.
WIDTH, 8, membrane-state and current width (unsigned).
BETA_SHIFT, 1, decay: decayed = state − (state >> BETA_SHIFT).
THRESHOLD_RST, 200, threshold register value after reset.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  reset; synchronous, active-high.
step_start  in  1  one-cycle pulse, begins a timestep; honoured only in IDLE.
cur_valid  in  1  current word valid.
cur_ready  out  1  scheduler accepts current for neuron `cur_idx`.
cur_data  in  WIDTH  input current.
cur_idx  out  $clog2(NUM_NEURONS)  index of the neuron whose current is requested.
spike_valid  out  1  spike record valid.
spike_ready  in  1  consumer accepts spike record.
spike_idx  out  $clog2(NUM_NEURONS)  neuron index of record.
spike_fire  out  1  1 = neuron fired this timestep.
spike_state  out  WIDTH  post-update membrane state.
cfg_we  in  1  write threshold; honoured only in IDLE.
cfg_threshold  in  WIDTH  new threshold value (0 is treated as 1).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at end of a timestep.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-step):
  - FSM→IDLE, neuron index→0, all membrane states→0, threshold→THRESHOLD_RST.
  - busy, done, cur_ready, spike_valid, spike_fire→0; spike_idx, spike_state→0.
- FSM states: IDLE, FETCH, UPDATE, EMIT, DONE.
  - IDLE: step_start=1 → FETCH, idx=0. cfg_we=1 → threshold ← max(cfg_threshold,1). If both are high in the same cycle, the write happens and the step also starts, using the new threshold.
  - FETCH: cur_ready=1, cur_idx=idx. Transfer when cur_valid&cur_ready: latch cur_data → UPDATE. Waits indefinitely if cur_valid stays low.
  - UPDATE (1 cycle):
    - decayed = s − (s>>BETA_SHIFT), computed in WIDTH+1 bits.
    - sum = decayed + current, saturated to 2^WIDTH−1.
    - If sum ≥ threshold: fire=1, s_new = sum − threshold (reset-by-subtraction). Else fire=0, s_new = sum.
    - Write s_new to state[idx]; register spike_idx/spike_fire/spike_state → EMIT.
  - EMIT: spike_valid=1, payload held stable until spike_valid&spike_ready. On transfer: if idx = NUM_NEURONS−1 → DONE, else idx+1 → FETCH.
  - DONE: done=1 for exactly one cycle → IDLE.
- step_start and cfg_we are ignored (no effect, no queuing) outside IDLE.
- Minimum timestep latency: step_start to done is 3·NUM_NEURONS+1 cycles with valid and ready held high.
- cur_ready and spike_valid are never asserted in the same cycle.
- The current used for a neuron is never reused across timesteps.
- Index wraps to 0 only via IDLE.

Decomposition:
- Shared package lif_pkg:
  - FSM state enum.
  - Default WIDTH/BETA_SHIFT/THRESHOLD constants.
  - Spike-record struct {idx, fire, state}.
- One sub-module, lif_update: purely combinational (s, current, threshold) → (s_new, fire), containing the decay, saturation and subtract logic.
- The scheduler owns the FSM, index counter, state register file and handshakes.

Test Plan:
1. Reset check: rst high 2 cycles → busy=0, done=0, cur_ready=0, spike_valid=0. A step with all currents 0 then emits four records with fire=0, state=0.
2. Single step, defaults (N=4, threshold=200, shift=1), currents 100,0,250,50 → records (0,0,100), (1,0,0), (2,1,50), (3,0,50). done pulses once; 13 cycles from start to done with ready/valid held high.
3. Second step, same currents → (0,0,150), (1,0,0), (2,1,275→sat 255−200=55), (3,0,75).
4. Saturation/threshold config:
   - In IDLE, cfg_we with threshold 255.
   - Step 1, neuron 0 current 254 → (0,0,254).
   - Step 2, current 200 → 127+200 saturates to 255 → (0,1,0).
5. Backpressure:
   - Hold cur_valid low 4 cycles in FETCH → no state change, cur_idx stable.
   - Hold spike_ready low 3 cycles in EMIT → spike_valid stays 1, payload stable, idx does not advance.
6. Illegal/abort:
   - step_start and cfg_we pulsed while busy → ignored; the step completes with the old threshold and exactly one done.
   - rst asserted during UPDATE of neuron 2 → next cycle IDLE, all states 0, no done pulse.

Source files
------------

// File: rtl/lif_pkg.sv
//==============================================================================
// Module      : lif_pkg
// Description : Shared constants, FSM encodings and spike record type for the
//               time-multiplexed LIF neuron scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package lif_pkg;

    localparam int unsigned c_num_neurons_def = 4;
    localparam int unsigned c_width_def       = 8;
    localparam int unsigned c_beta_shift_def  = 1;
    localparam int unsigned c_threshold_def   = 200;

    // Scheduler FSM encoding
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_update = 3'd2;
    localparam logic [2:0] c_st_emit   = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    typedef logic [2:0] lif_state_t;

    // Spike record layout for the default configuration
    typedef struct packed {
        logic [$clog2(c_num_neurons_def)-1:0] idx;
        logic                                 fire;
        logic [c_width_def-1:0]               state;
    } lif_spike_rec_t;

endpackage : lif_pkg

`default_nettype wire

// File: rtl/lif_update.sv
//==============================================================================
// Module      : lif_update
// Description : Combinational LIF step: decay, add current with saturation,
//               threshold compare and reset-by-subtraction.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH      = c_width_def,
    parameter int unsigned BETA_SHIFT = c_beta_shift_def
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic [WIDTH-1:0] i_current,
    input  logic [WIDTH-1:0] i_threshold,
    output logic [WIDTH-1:0] o_state_new,
    output logic             o_fire
);

    logic [WIDTH:0]   w_state_ext;
    logic [WIDTH:0]   w_decayed;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sat;

    assign w_state_ext = {1'b0, i_state};
    assign w_decayed   = w_state_ext - (w_state_ext >> BETA_SHIFT);
    // One extra bit holds the carry so saturation can be detected exactly
    assign w_sum       = w_decayed + {1'b0, i_current};
    assign w_sat       = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

    assign o_fire      = (w_sat >= i_threshold);
    assign o_state_new = o_fire ? (w_sat - i_threshold) : w_sat;

endmodule : lif_update

`default_nettype wire

// File: rtl/lif_scheduler.sv
//==============================================================================
// Module      : lif_scheduler
// Description : Shares one LIF update datapath across NUM_NEURONS neurons,
//               fetching currents and emitting spike records over valid/ready.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lif_scheduler
    import lif_pkg::*;
#(
    parameter int unsigned NUM_NEURONS   = c_num_neurons_def,
    parameter int unsigned WIDTH         = c_width_def,
    parameter int unsigned BETA_SHIFT    = c_beta_shift_def,
    parameter int unsigned THRESHOLD_RST = c_threshold_def
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step_start,
    input  logic                           cur_valid,
    output logic                           cur_ready,
    input  logic [WIDTH-1:0]               cur_data,
    output logic [$clog2(NUM_NEURONS)-1:0] cur_idx,
    output logic                           spike_valid,
    input  logic                           spike_ready,
    output logic [$clog2(NUM_NEURONS)-1:0] spike_idx,
    output logic                           spike_fire,
    output logic [WIDTH-1:0]               spike_state,
    input  logic                           cfg_we,
    input  logic [WIDTH-1:0]               cfg_threshold,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned              c_idx_w    = $clog2(NUM_NEURONS);
    localparam logic [c_idx_w-1:0]       c_last_idx = c_idx_w'(NUM_NEURONS - 1);
    localparam logic [WIDTH-1:0]         c_thr_rst  = WIDTH'(THRESHOLD_RST);
    localparam logic [WIDTH-1:0]         c_thr_min  = WIDTH'(1);

    typedef struct packed {
        logic [c_idx_w-1:0] idx;
        logic               fire;
        logic [WIDTH-1:0]   state;
    } rec_t;

    lif_state_t         r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_thr;
    logic [WIDTH-1:0]   r_cur;
    logic [WIDTH-1:0]   r_mem [NUM_NEURONS];
    rec_t               r_spike;

    logic [WIDTH-1:0]   w_state_cur;
    logic [WIDTH-1:0]   w_state_new;
    logic               w_fire;

    assign w_state_cur = r_mem[r_idx];

    lif_update #(
        .WIDTH      (WIDTH),
        .BETA_SHIFT (BETA_SHIFT)
    ) u_update (
        .i_state     (w_state_cur),
        .i_current   (r_cur),
        .i_threshold (r_thr),
        .o_state_new (w_state_new),
        .o_fire      (w_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
            r_thr   <= c_thr_rst;
            r_cur   <= '0;
            r_spike <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // A same-cycle config write lands before the step uses it
                    if (cfg_we) begin
                        r_thr <= (cfg_threshold == '0) ? c_thr_min : cfg_threshold;
                    end
                    if (step_start) begin
                        r_idx   <= '0;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    if (cur_valid) begin
                        r_cur   <= cur_data;
                        r_state <= c_st_update;
                    end
                end
                c_st_update: begin
                    r_spike.idx   <= r_idx;
                    r_spike.fire  <= w_fire;
                    r_spike.state <= w_state_new;
                    r_state       <= c_st_emit;
                end
                c_st_emit: begin
                    if (spike_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= c_st_done;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= c_st_fetch;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == c_st_update) begin
            r_mem[r_idx] <= w_state_new;
        end
    end

    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign cur_ready   = (r_state == c_st_fetch);
    assign cur_idx     = r_idx;
    assign spike_valid = (r_state == c_st_emit);
    assign spike_idx   = r_spike.idx;
    assign spike_fire  = r_spike.fire;
    assign spike_state = r_spike.state;

endmodule : lif_scheduler

`default_nettype wire

// File: tb/tb_lif_scheduler.sv
//==============================================================================
// Module      : tb_lif_scheduler
// Description : Directed self-checking bench for lif_scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lif_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    typedef logic [W-1:0] vec_t [N];

    logic         clk = 1'b0;
    logic         rst;
    logic         step_start;
    logic         cur_valid;
    logic         cur_ready;
    logic [W-1:0] cur_data;
    logic [1:0]   cur_idx;
    logic         spike_valid;
    logic         spike_ready;
    logic [1:0]   spike_idx;
    logic         spike_fire;
    logic [W-1:0] spike_state;
    logic         cfg_we;
    logic [W-1:0] cfg_threshold;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    lif_scheduler #(
        .NUM_NEURONS   (N),
        .WIDTH         (W),
        .BETA_SHIFT    (1),
        .THRESHOLD_RST (200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .step_start    (step_start),
        .cur_valid     (cur_valid),
        .cur_ready     (cur_ready),
        .cur_data      (cur_data),
        .cur_idx       (cur_idx),
        .spike_valid   (spike_valid),
        .spike_ready   (spike_ready),
        .spike_idx     (spike_idx),
        .spike_fire    (spike_fire),
        .spike_state   (spike_state),
        .cfg_we        (cfg_we),
        .cfg_threshold (cfg_threshold),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full timestep with valid/ready held high; optionally pokes step_start
    // and cfg_we mid-step, which must have no effect.
    task automatic run_step(input string tag, input vec_t cur, input logic [N-1:0] exp_fire,
                            input vec_t exp_state, input bit abuse);
        int cyc;
        int rec;
        int overlap;
        bit fin;
        cyc = 0; rec = 0; overlap = 0; fin = 1'b0;
        step_start  = 1'b1;
        cur_valid   = 1'b1;
        spike_ready = 1'b1;
        cur_data    = cur[0];
        while (!fin && cyc < 60) begin
            tick();
            cyc++;
            step_start = 1'b0;
            cfg_we     = 1'b0;
            if (abuse && (cyc == 4 || cyc == 8)) begin
                step_start    = 1'b1;
                cfg_we        = 1'b1;
                cfg_threshold = 8'd255;
            end
            if (cur_ready && spike_valid) overlap++;
            if (spike_valid) begin
                if (rec < N) begin
                    check({tag, " idx"},   32'(spike_idx),   32'(rec));
                    check({tag, " fire"},  32'(spike_fire),  32'(exp_fire[rec]));
                    check({tag, " state"}, 32'(spike_state), 32'(exp_state[rec]));
                end
                rec++;
            end
            if (done) begin
                check({tag, " latency"}, 32'(cyc), 32'd13);
                fin = 1'b1;
            end
            cur_data = cur[cur_idx];
        end
        step_start = 1'b0;
        cfg_we     = 1'b0;
        check({tag, " done seen"}, 32'(fin), 32'd1);
        check({tag, " records"}, 32'(rec), 32'(N));
        check({tag, " ready/valid overlap"}, 32'(overlap), 32'd0);
        tick();
        check({tag, " single done"}, 32'(done), 32'd0);
        check({tag, " idle after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t cv;
        vec_t ev;
        int   dsum;
        rst = 1'b1; step_start = 1'b0; cur_valid = 1'b0; cur_data = '0;
        spike_ready = 1'b0; cfg_we = 1'b0; cfg_threshold = '0;

        // Reset state
        repeat (2) tick();
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst cur_ready", 32'(cur_ready), 0);
        check("rst spike_valid", 32'(spike_valid), 0);
        check("rst spike_fire", 32'(spike_fire), 0);
        check("rst spike_idx", 32'(spike_idx), 0);
        check("rst spike_state", 32'(spike_state), 0);
        check("rst cur_idx", 32'(cur_idx), 0);
        rst = 1'b0;

        cv = '{8'd0, 8'd0, 8'd0, 8'd0};
        ev = '{8'd0, 8'd0, 8'd0, 8'd0};
        run_step("zero step", cv, 4'b0000, ev, 1'b0);

        // Default threshold 200, two identical steps
        cv = '{8'd100, 8'd0, 8'd250, 8'd50};
        ev = '{8'd100, 8'd0, 8'd50, 8'd50};
        run_step("step1", cv, 4'b0100, ev, 1'b0);
        ev = '{8'd150, 8'd0, 8'd55, 8'd75};
        run_step("step2", cv, 4'b0100, ev, 1'b0);

        // Threshold 255 and saturation
        rst = 1'b1; tick(); rst = 1'b0;
        cfg_we = 1'b1; cfg_threshold = 8'd255; tick(); cfg_we = 1'b0;
        cv = '{8'd254, 8'd0, 8'd0, 8'd0};
        ev = '{8'd254, 8'd0, 8'd0, 8'd0};
        run_step("thr255 a", cv, 4'b0000, ev, 1'b0);
        cv = '{8'd200, 8'd0, 8'd0, 8'd0};
        ev = '{8'd0, 8'd0, 8'd0, 8'd0};
        run_step("thr255 sat", cv, 4'b0001, ev, 1'b0);

        // Backpressure on both streams
        rst = 1'b1; tick(); rst = 1'b0;
        step_start = 1'b1; cur_valid = 1'b0; spike_ready = 1'b0; cur_data = 8'd30;
        tick();
        step_start = 1'b0;
        repeat (4) tick();
        check("bp fetch cur_ready", 32'(cur_ready), 1);
        check("bp fetch cur_idx", 32'(cur_idx), 0);
        check("bp fetch spike_valid", 32'(spike_valid), 0);
        check("bp fetch busy", 32'(busy), 1);
        cur_valid = 1'b1;
        tick();
        cur_valid = 1'b0;
        check("bp update cur_ready", 32'(cur_ready), 0);
        tick();
        check("bp emit valid", 32'(spike_valid), 1);
        repeat (3) tick();
        check("bp hold valid", 32'(spike_valid), 1);
        check("bp hold idx", 32'(spike_idx), 0);
        check("bp hold state", 32'(spike_state), 30);
        check("bp hold fire", 32'(spike_fire), 0);
        check("bp hold cur_ready", 32'(cur_ready), 0);
        check("bp hold cur_idx", 32'(cur_idx), 0);
        spike_ready = 1'b1;
        tick();
        check("bp next cur_ready", 32'(cur_ready), 1);
        check("bp next cur_idx", 32'(cur_idx), 1);
        cur_valid = 1'b1; cur_data = 8'd0;
        for (int i = 0; i < 40 && !done; i++) tick();
        check("bp done", 32'(done), 1);
        tick();

        // Ignored step_start/cfg_we while busy; states now {30,0,0,0}
        cv = '{8'd0, 8'd0, 8'd0, 8'd210};
        ev = '{8'd15, 8'd0, 8'd0, 8'd10};
        run_step("busy abuse", cv, 4'b1000, ev, 1'b1);

        // Threshold write of 0 behaves as 1
        cfg_we = 1'b1; cfg_threshold = 8'd0; tick(); cfg_we = 1'b0;
        cv = '{8'd0, 8'd0, 8'd0, 8'd0};
        ev = '{8'd7, 8'd0, 8'd0, 8'd4};
        run_step("thr zero", cv, 4'b1001, ev, 1'b0);

        // Reset during UPDATE of neuron 2
        step_start = 1'b1; cur_valid = 1'b1; spike_ready = 1'b1; cur_data = 8'd50;
        tick();
        step_start = 1'b0;
        repeat (7) tick();
        check("abort in update cur_idx", 32'(cur_idx), 2);
        check("abort in update cur_ready", 32'(cur_ready), 0);
        check("abort in update spike_valid", 32'(spike_valid), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort cur_ready", 32'(cur_ready), 0);
        check("abort spike_valid", 32'(spike_valid), 0);
        check("abort spike_idx", 32'(spike_idx), 0);
        check("abort spike_state", 32'(spike_state), 0);
        check("abort cur_idx", 32'(cur_idx), 0);
        cur_valid = 1'b0; spike_ready = 1'b0;
        dsum = 0;
        repeat (5) begin
            tick();
            dsum += 32'(done);
        end
        check("abort no done", 32'(dsum), 0);
        cv = '{8'd0, 8'd0, 8'd0, 8'd150};
        ev = '{8'd0, 8'd0, 8'd0, 8'd150};
        run_step("after abort", cv, 4'b0000, ev, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lif_scheduler

`default_nettype wire
